// File: rtl/sound_pkg.sv
// rtl/sound_pkg.sv - shared constants for the sound latch controller
package sound_pkg;

  localparam int IRQ_DIV_DEFAULT = 512;
  localparam int CNT_W_DEFAULT   = 10;
  localparam int LATCH_W         = 8;

  localparam logic [7:0] LATCH_CLR_PORT = 8'h04;
  localparam logic [7:0] LATCH_RD_PORT  = 8'h06;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - 1-bit registered rising-edge detector
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic prev;

  // Remember last cycle's level so a held level yields a single pulse
  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b0;
    else       prev <= din;
  end

  assign pulse = din & ~prev;

endmodule

// File: rtl/sound_latch_ctrl.sv
// rtl/sound_latch_ctrl.sv - 68K-to-Z80 sound command latch and Z80 periodic interrupt
module sound_latch_ctrl
  import sound_pkg::*;
#(
  parameter int IRQ_DIV = IRQ_DIV_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               z80_cen,
  input  logic               m68k_latch_cs,
  input  logic               m68k_rw,
  input  logic               m68k_lds_n,
  input  logic [LATCH_W-1:0] m68k_dout,
  input  logic               z80_latch_r_cs,
  input  logic               z80_latch_clr_cs,
  input  logic               z80_rd_n,
  input  logic               z80_wr_n,
  input  logic               z80_m1_n,
  input  logic               z80_iorq_n,
  output logic [LATCH_W-1:0] sound_latch,
  output logic               latch_pending,
  output logic [LATCH_W-1:0] z80_latch_dout,
  output logic               z80_int_n
);

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(IRQ_DIV - 1);

  logic wr_ev;
  logic clr_ev;
  logic ack;
  logic tick;
  logic irq_req;
  logic [CNT_W-1:0] div_cnt;

  // Only lower-byte 68K writes to the latch address carry the command byte
  rise_detect u_wr_det (
    .clk   (clk),
    .reset (reset),
    .din   (m68k_latch_cs & ~m68k_rw & ~m68k_lds_n),
    .pulse (wr_ev)
  );

  // Either a read or a write cycle on the clear port clears the latch
  rise_detect u_clr_det (
    .clk   (clk),
    .reset (reset),
    .din   (z80_latch_clr_cs & (~z80_rd_n | ~z80_wr_n)),
    .pulse (clr_ev)
  );

  // M1 together with IORQ is the Z80 interrupt acknowledge cycle
  rise_detect u_ack_det (
    .clk   (clk),
    .reset (reset),
    .din   (~z80_m1_n & ~z80_iorq_n),
    .pulse (ack)
  );

  // Latch update; a new command takes priority over a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      sound_latch   <= '0;
      latch_pending <= 1'b0;
    end else if (wr_ev) begin
      sound_latch   <= m68k_dout;
      latch_pending <= 1'b1;
    end else if (clr_ev) begin
      sound_latch   <= '0;
      latch_pending <= 1'b0;
    end
  end

  assign tick = z80_cen && (div_cnt == DIV_LAST);

  // Free-running interrupt divider on the Z80 clock-enable
  always_ff @(posedge clk) begin
    if (reset)        div_cnt <= '0;
    else if (z80_cen) div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
  end

  // Interrupt request held until acknowledged; a tick beats a same-cycle ack
  always_ff @(posedge clk) begin
    if (reset)     irq_req <= 1'b0;
    else if (tick) irq_req <= 1'b1;
    else if (ack)  irq_req <= 1'b0;
  end

  assign z80_int_n      = ~irq_req;
  assign z80_latch_dout = (z80_latch_r_cs & ~z80_rd_n) ? sound_latch : '1;

endmodule

// File: tb/tb_sound_latch_ctrl.sv
// tb/tb_sound_latch_ctrl.sv - directed self-checking bench for sound_latch_ctrl
module tb_sound_latch_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       z80_cen;
  logic       m68k_latch_cs;
  logic       m68k_rw;
  logic       m68k_lds_n;
  logic [7:0] m68k_dout;
  logic       z80_latch_r_cs;
  logic       z80_latch_clr_cs;
  logic       z80_rd_n;
  logic       z80_wr_n;
  logic       z80_m1_n;
  logic       z80_iorq_n;
  logic [7:0] sound_latch;
  logic       latch_pending;
  logic [7:0] z80_latch_dout;
  logic       z80_int_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sound_latch_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .z80_cen          (z80_cen),
    .m68k_latch_cs    (m68k_latch_cs),
    .m68k_rw          (m68k_rw),
    .m68k_lds_n       (m68k_lds_n),
    .m68k_dout        (m68k_dout),
    .z80_latch_r_cs   (z80_latch_r_cs),
    .z80_latch_clr_cs (z80_latch_clr_cs),
    .z80_rd_n         (z80_rd_n),
    .z80_wr_n         (z80_wr_n),
    .z80_m1_n         (z80_m1_n),
    .z80_iorq_n       (z80_iorq_n),
    .sound_latch      (sound_latch),
    .latch_pending    (latch_pending),
    .z80_latch_dout   (z80_latch_dout),
    .z80_int_n        (z80_int_n)
  );

  typedef struct {
    logic       cs;
    logic       rw;
    logic       lds_n;
    logic [7:0] d;
    logic       clr;
    logic       rd_n;
    logic       wr_n;
    logic       rcs;
    logic [7:0] e_latch;
    logic       e_pend;
    logic [7:0] e_dout;
  } vec_t;

  vec_t vecs[19];
  logic saw_high;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    m68k_latch_cs    = 1'b0;
    m68k_rw          = 1'b1;
    m68k_lds_n       = 1'b1;
    m68k_dout        = 8'h00;
    z80_latch_r_cs   = 1'b0;
    z80_latch_clr_cs = 1'b0;
    z80_rd_n         = 1'b1;
    z80_wr_n         = 1'b1;
  endtask

  // One clock with the given cen/ack levels; sampling is 1 time unit after the edge
  task automatic clk1(input logic cen, input logic ak);
    z80_cen    = cen;
    z80_m1_n   = ~ak;
    z80_iorq_n = ~ak;
    @(posedge clk);
    #1;
    z80_cen    = 1'b0;
    z80_m1_n   = 1'b1;
    z80_iorq_n = 1'b1;
  endtask

  // n cen pulses, one every 4 clks, optionally watching that INT stays low
  task automatic cen_pulses(input int n, input logic watch_low);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        clk1(k == 3, 1'b0);
        if (watch_low && z80_int_n !== 1'b0) saw_high = 1'b1;
      end
    end
  endtask

  task automatic write_q(input logic [7:0] d);
    m68k_latch_cs = 1'b1;
    m68k_rw       = 1'b0;
    m68k_lds_n    = 1'b0;
    m68k_dout     = d;
  endtask

  initial begin
    //          cs  rw  lds d      clr rd  wr  rcs  latch  pend  dout
    vecs[0]  = '{0, 1, 1, 8'h00, 0, 1, 1, 0, 8'h00, 0, 8'hFF};
    vecs[1]  = '{1, 0, 0, 8'h5A, 0, 1, 1, 0, 8'h5A, 1, 8'hFF};
    vecs[2]  = '{1, 0, 0, 8'h11, 0, 1, 1, 0, 8'h5A, 1, 8'hFF};
    vecs[3]  = '{1, 0, 0, 8'h22, 0, 1, 1, 0, 8'h5A, 1, 8'hFF};
    vecs[4]  = '{0, 1, 1, 8'h00, 0, 1, 1, 0, 8'h5A, 1, 8'hFF};
    vecs[5]  = '{1, 0, 0, 8'h33, 0, 1, 1, 0, 8'h33, 1, 8'hFF};
    vecs[6]  = '{0, 1, 1, 8'h00, 0, 0, 1, 1, 8'h33, 1, 8'h33};
    vecs[7]  = '{0, 1, 1, 8'h00, 0, 1, 1, 0, 8'h33, 1, 8'hFF};
    vecs[8]  = '{0, 1, 1, 8'h00, 1, 0, 1, 0, 8'h00, 0, 8'hFF};
    vecs[9]  = '{0, 1, 1, 8'h00, 0, 1, 1, 0, 8'h00, 0, 8'hFF};
    vecs[10] = '{1, 0, 0, 8'hC3, 1, 1, 0, 0, 8'hC3, 1, 8'hFF};
    vecs[11] = '{0, 1, 1, 8'h00, 0, 1, 1, 0, 8'hC3, 1, 8'hFF};
    vecs[12] = '{0, 1, 1, 8'h00, 1, 1, 0, 0, 8'h00, 0, 8'hFF};
    vecs[13] = '{0, 1, 1, 8'h00, 0, 1, 1, 0, 8'h00, 0, 8'hFF};
    vecs[14] = '{1, 0, 1, 8'h99, 0, 1, 1, 0, 8'h00, 0, 8'hFF};
    vecs[15] = '{0, 1, 1, 8'h00, 0, 1, 1, 0, 8'h00, 0, 8'hFF};
    vecs[16] = '{1, 1, 0, 8'hAB, 0, 1, 1, 0, 8'h00, 0, 8'hFF};
    vecs[17] = '{0, 1, 1, 8'h00, 0, 1, 1, 1, 8'h00, 0, 8'hFF};
    vecs[18] = '{0, 1, 1, 8'h00, 0, 0, 1, 1, 8'h00, 0, 8'h00};

    reset      = 1'b1;
    z80_cen    = 1'b0;
    z80_m1_n   = 1'b1;
    z80_iorq_n = 1'b1;
    saw_high   = 1'b0;
    idle_bus();
    clk1(1'b0, 1'b0);
    clk1(1'b0, 1'b0);
    check("reset_latch", sound_latch, 8'h00);
    check("reset_pending", {7'b0, latch_pending}, 8'h00);
    check("reset_int_n", {7'b0, z80_int_n}, 8'h01);
    reset = 1'b0;

    // Latch write / read / clear behaviour
    for (int i = 0; i < 19; i++) begin
      m68k_latch_cs    = vecs[i].cs;
      m68k_rw          = vecs[i].rw;
      m68k_lds_n       = vecs[i].lds_n;
      m68k_dout        = vecs[i].d;
      z80_latch_clr_cs = vecs[i].clr;
      z80_rd_n         = vecs[i].rd_n;
      z80_wr_n         = vecs[i].wr_n;
      z80_latch_r_cs   = vecs[i].rcs;
      clk1(1'b0, 1'b0);
      check($sformatf("vec%0d_latch", i), sound_latch, vecs[i].e_latch);
      check($sformatf("vec%0d_pending", i), {7'b0, latch_pending}, {7'b0, vecs[i].e_pend});
      check($sformatf("vec%0d_dout", i), z80_latch_dout, vecs[i].e_dout);
    end
    idle_bus();

    // Interrupt period: divider is still 0 since no cen pulses so far
    cen_pulses(511, 1'b0);
    check("int_before_tick", {7'b0, z80_int_n}, 8'h01);
    cen_pulses(1, 1'b0);
    check("int_at_tick", {7'b0, z80_int_n}, 8'h00);
    saw_high = 1'b0;
    cen_pulses(1536, 1'b1);
    check("int_held_3_periods", {7'b0, saw_high}, 8'h00);
    clk1(1'b0, 1'b1);
    check("int_after_ack", {7'b0, z80_int_n}, 8'h01);
    cen_pulses(511, 1'b0);
    check("int_before_next_tick", {7'b0, z80_int_n}, 8'h01);
    cen_pulses(1, 1'b0);
    check("int_next_tick", {7'b0, z80_int_n}, 8'h00);

    // Ack arriving on the tick clk: tick wins
    clk1(1'b0, 1'b1);
    check("int_cleared_again", {7'b0, z80_int_n}, 8'h01);
    cen_pulses(511, 1'b0);
    clk1(1'b0, 1'b0);
    clk1(1'b0, 1'b0);
    clk1(1'b0, 1'b0);
    clk1(1'b1, 1'b1);
    check("tick_beats_ack", {7'b0, z80_int_n}, 8'h00);
    clk1(1'b0, 1'b0);
    check("tick_beats_ack_hold", {7'b0, z80_int_n}, 8'h00);

    // Reset in the middle of a write with the interrupt pending
    write_q(8'h5A);
    clk1(1'b0, 1'b0);
    check("pre_reset_latch", sound_latch, 8'h5A);
    reset = 1'b1;
    clk1(1'b0, 1'b0);
    check("mid_reset_latch", sound_latch, 8'h00);
    check("mid_reset_pending", {7'b0, latch_pending}, 8'h00);
    check("mid_reset_int_n", {7'b0, z80_int_n}, 8'h01);
    m68k_dout = 8'hD2;
    clk1(1'b0, 1'b0);
    check("reset_held_latch", sound_latch, 8'h00);
    reset = 1'b0;
    clk1(1'b0, 1'b0);
    check("post_reset_write", sound_latch, 8'hD2);
    check("post_reset_pending", {7'b0, latch_pending}, 8'h01);
    m68k_dout = 8'hE1;
    clk1(1'b0, 1'b0);
    check("post_reset_single_write", sound_latch, 8'hD2);
    idle_bus();

    // Divider restarted from 0 by the reset
    cen_pulses(511, 1'b0);
    check("post_reset_no_tick", {7'b0, z80_int_n}, 8'h01);
    cen_pulses(1, 1'b0);
    check("post_reset_tick", {7'b0, z80_int_n}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sound_latch_ctrl.md
Name: sound_latch_ctrl

Overview:
Sits between the address decoder and the sound Z80.
- Captures the 68K's 8-bit sound command into a latch.
- Presents that byte to the Z80 I/O read path and lets the Z80 clear it.
- Generates the Z80's periodic maskable interrupt at 4 MHz/512 (~7.8 kHz), held until the Z80 acknowledges it.
- All state is in the single system clock domain. The Z80 timebase comes from a clock-enable.

Parameters:
IRQ_DIV, 512, number of z80_cen pulses per Z80 interrupt period.
CNT_W, 10, width of the interrupt divider counter; must satisfy 2^CNT_W >= IRQ_DIV.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
z80_cen  input  1  Z80 clock-enable pulse, one clk wide
m68k_latch_cs  input  1  68K sound-latch select from the address decoder
m68k_rw  input  1  68K R/W, 1 = read
m68k_lds_n  input  1  68K lower data strobe, active low
m68k_dout  input  8  68K data bus D[7:0]
z80_latch_r_cs  input  1  Z80 I/O select, latch read port (0x06)
z80_latch_clr_cs  input  1  Z80 I/O select, latch clear port (0x04)
z80_rd_n  input  1  Z80 RD, active low
z80_wr_n  input  1  Z80 WR, active low
z80_m1_n  input  1  Z80 M1, active low
z80_iorq_n  input  1  Z80 IORQ, active low
sound_latch  output  8  current latch contents
latch_pending  output  1  1 = latch written and not yet cleared
z80_latch_dout  output  8  Z80 read data; sound_latch when z80_latch_r_cs & !z80_rd_n, else 8'hFF
z80_int_n  output  1  Z80 INT, active low

Behaviour:
- Reset values (while reset = 1, synchronously):
  - sound_latch = 0, latch_pending = 0, z80_int_n = 1.
  - Divider = 0. All edge-detect history registers = 0.
- Write event (wr_ev):
  - Condition: rising edge of (m68k_latch_cs & !m68k_rw & !m68k_lds_n), compared against its value registered on the previous clk.
  - Action: on that clk, sound_latch <= m68k_dout and latch_pending <= 1.
  - Result is visible 1 clk later.
  - A long bus cycle with the condition held high gives exactly one write.
  - Upper-byte-only writes (lds_n = 1) are ignored.
- Clear event (clr_ev):
  - Condition: rising edge of (z80_latch_clr_cs & (!z80_rd_n | !z80_wr_n)).
  - Action: sound_latch <= 0, latch_pending <= 0.
- wr_ev and clr_ev on the same clk: write wins; latch = new data, pending = 1.
- Read path:
  - z80_latch_dout is combinational from the register.
  - Reading has no side effects; pending is unchanged.
- Interrupt divider:
  - Counts on z80_cen only, 0..IRQ_DIV-1.
  - On the z80_cen pulse that wraps from IRQ_DIV-1 to 0, a tick is generated and irq_req is set.
  - z80_int_n = !irq_req, registered.
- Interrupt acknowledge (ack):
  - Condition: rising edge of (!z80_m1_n & !z80_iorq_n).
  - Action: clears irq_req.
- tick and ack on the same clk: tick wins; z80_int_n stays 0.
- Further ticks while irq_req = 1 are absorbed: no queueing, no counter stall.
- Divider free-runs regardless of latch activity.
- Reset asserted mid-operation (including mid-bus-cycle): all state returns to reset values.
  - Edge history returns to 0, so a select still held high when reset releases registers as a new edge on the first clk after release.
  - This is intended: it matches the power-on hardware.

Decomposition:
- Shared package (sound_pkg):
  - IRQ_DIV default.
  - LATCH_W = 8.
  - Z80 I/O port constants: LATCH_CLR_PORT = 8'h04, LATCH_RD_PORT = 8'h06.
- One natural sub-module: rise_detect.
  - 1-bit registered edge detector with synchronous reset.
  - Instantiated three times: wr_ev, clr_ev, ack.
- Divider and irq_req stay inline.

Test Plan:
1. Reset, then a 68K write with m68k_dout = 8'h5A held 4 clks → sound_latch = 8'h5A and latch_pending = 1 exactly 1 clk after the first qualifying clk; only one write event.
2. Write 8'h33, then Z80 read (z80_latch_r_cs = 1, z80_rd_n = 0) → z80_latch_dout = 8'h33, pending stays 1. Then an access on the clear port → sound_latch = 0, pending = 0. A read with no select → 8'hFF.
3. Write event and clear event on the same clk, data 8'hC3 → sound_latch = 8'hC3, latch_pending = 1.
4. z80_cen every 4 clks → z80_int_n falls after 512 cen pulses (2048 clks) and stays low across 3 further periods. Then M1 & IORQ low → z80_int_n = 1 the next clk; it falls again at the next tick.
5. Align ack with the tick clk → z80_int_n remains 0. Also drive m68k_lds_n = 1 during a write → latch unchanged.
6. Assert reset mid-write and with irq pending → all outputs return to reset values next clk. Holding m68k_latch_cs write-qualified through reset release → one write 1 clk after release.
